// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer sharing one memory port.
// Optional: define SEQ_TIMEOUT_EN to fault when mem_ack does not arrive within TIMEOUT request cycles.
//
// state   | meaning
// IDLE    | waiting for run at an instruction boundary
// FETCH   | instruction read from PC, ir loads on ack
// DECODE  | PC+1 strobe, halt check
// EXEC    | branch resolve or dispatch to MEM/WB
// MEM     | data access at ALU address
// WB      | register-file write strobe
// HALT    | sticky halt
// FAULT   | sticky memory timeout
module instr_sequencer #(
  parameter int InstrWidth = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  mem_ack,
  input  logic [InstrWidth-1:0] mem_rdata,
  input  logic                  dec_halt,
  input  logic                  dec_branch,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_reg_write,
  input  logic                  alu_zero,
  output logic [InstrWidth-1:0] ir,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_data_sel,
  output logic                  pc_inc,
  output logic                  pc_load_branch,
  output logic                  reg_write_en,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t                r_state;
  logic [InstrWidth-1:0] r_ir;
  state_t                w_boundary;
  logic                  w_expired;
  logic                  w_req_state;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("instr_sequencer: TIMEOUT must be in 1..255");
  end

  assign w_boundary  = run ? S_FETCH : S_IDLE;
  assign w_req_state = (r_state == S_FETCH) || (r_state == S_MEM);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
  logic [7:0] r_wait;

  // The counter is zero whenever a request phase starts, so it needs no explicit entry clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_wait <= '0;
    else if (w_req_state && !mem_ack) r_wait <= r_wait + 8'd1;
    else                            r_wait <= '0;
  end

  assign w_expired = w_req_state && !mem_ack && (r_wait == WaitLast);
  assign fault     = (r_state == S_FAULT);
`else
  assign w_expired = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_state <= S_DECODE;
          end else if (w_expired) begin
            r_state <= S_FAULT;
          end
        end
        S_DECODE: r_state <= dec_halt ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (dec_branch)                       r_state <= w_boundary;
          else if (dec_mem_write || dec_mem_read) r_state <= S_MEM;
          else if (dec_reg_write)               r_state <= S_WB;
          else                                  r_state <= w_boundary;
        end
        S_MEM: begin
          if (mem_ack)        r_state <= dec_mem_write ? w_boundary : S_WB;
          else if (w_expired) r_state <= S_FAULT;
        end
        S_WB:    r_state <= w_boundary;
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign ir             = r_ir;
  assign mem_req        = w_req_state;
  assign mem_data_sel   = (r_state == S_MEM);
  assign mem_we         = (r_state == S_MEM) && dec_mem_write;
  assign pc_inc         = (r_state == S_DECODE);
  assign pc_load_branch = (r_state == S_EXEC) && dec_branch && alu_zero;
  assign reg_write_en   = (r_state == S_WB);
  assign busy           = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC) ||
                          (r_state == S_MEM)   || (r_state == S_WB);
  assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each instruction into its
// expected per-cycle outputs; one runner drives and compares them, plus literal spot checks.
module tb_instr_sequencer;
  localparam int IW = 16;
  localparam int TO = 4;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, mem_ack = 1'b0, alu_zero = 1'b0;
  logic dec_halt = 1'b0, dec_branch = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic [IW-1:0] ir;
  logic mem_req, mem_we, mem_data_sel, pc_inc, pc_load_branch, reg_write_en, busy, halted, fault;

  always #5 clk = ~clk;

  instr_sequencer #(.InstrWidth(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dec_halt(dec_halt), .dec_branch(dec_branch), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write), .alu_zero(alu_zero),
    .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .mem_data_sel(mem_data_sel),
    .pc_inc(pc_inc), .pc_load_branch(pc_load_branch), .reg_write_en(reg_write_en),
    .busy(busy), .halted(halted), .fault(fault)
  );

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BR, K_NOP, K_HALT} kind_e;

  // exp bit order: req we sel pc_inc pc_load_branch reg_write_en busy halted fault
  typedef struct packed {
    logic run, ack, h, b, r, w, rw, az;
    logic [IW-1:0] rdata;
    logic [IW-1:0] ir;
    logic [8:0]    exp;
  } step_t;

  step_t q[$];
  int checks = 0;
  int failures = 0;
  logic [IW-1:0] m_ir;
  bit m_halt, m_fault;
  logic f_h, f_b, f_r, f_w, f_rw, f_az;

  function automatic logic [8:0] outs();
    return {mem_req, mem_we, mem_data_sel, pc_inc, pc_load_branch, reg_write_en, busy, halted, fault};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [IW-1:0] rnd();
    return IW'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add_step(input logic r, input logic a, input logic [IW-1:0] d, input logic [8:0] e);
    step_t s;
    s.run = r; s.ack = a; s.rdata = d; s.exp = e; s.ir = m_ir;
    s.h = f_h; s.b = f_b; s.r = f_r; s.w = f_w; s.rw = f_rw; s.az = f_az;
    q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add_step(i == n - 1, rb(), rnd(), 9'b0);
  endtask

  task automatic stuck(input int n);
    for (int i = 0; i < n; i++) add_step(rb(), rb(), rnd(), {7'b0, m_halt, m_fault});
  endtask

  // Request phase: wt cycles without ack, then the ack cycle, unless the timeout fires first.
  task automatic req_phase(input int wt, input logic sel, input logic we, input logic [IW-1:0] d,
                           input logic last_run, input logic last_bnd, output bit ok);
    ok = 1'b1;
    for (int c = 0; c <= wt; c++) begin
      if (c == wt) begin
        add_step(last_bnd ? last_run : rb(), 1'b1, d, {1'b1, we, sel, 3'b000, 1'b1, 2'b00});
      end else begin
        add_step(rb(), 1'b0, rnd(), {1'b1, we, sel, 3'b000, 1'b1, 2'b00});
        if (TO_EN && c == TO - 1) begin
          m_fault = 1'b1;
          ok = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic instr(input kind_e k, input int fw, input int mw, input logic az, input logic cont);
    logic [IW-1:0] word;
    logic [3:0] op;
    bit ok, bnd;
    if (m_halt || m_fault) return;
    f_h = (k == K_HALT); f_b = (k == K_BR); f_w = (k == K_STORE);
    f_r = (k == K_LOAD) || (k == K_STORE);
    f_rw = (k == K_ALU) || (k == K_LOAD) || (k == K_BR);
    f_az = az;
    op = (k == K_HALT) ? 4'hF : 4'(int'(k) + 1);
    word = {op, 12'($urandom)};
    req_phase(fw, 1'b0, 1'b0, word, 1'b0, 1'b0, ok);
    if (!ok) return;
    m_ir = word;
    add_step(rb(), rb(), rnd(), 9'b000100100);
    if (f_h) begin
      m_halt = 1'b1;
      return;
    end
    bnd = f_b || !(f_r || f_w || f_rw);
    add_step(bnd ? cont : rb(), rb(), rnd(), {4'b0000, f_b & az, 1'b0, 1'b1, 2'b00});
    if (bnd) return;
    if (f_r || f_w) begin
      req_phase(mw, 1'b1, f_w, rnd(), cont, f_w, ok);
      if (!ok || f_w) return;
    end
    add_step(cont, rb(), rnd(), 9'b000001100);
  endtask

  task automatic run_queue(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clk);
      run = s.run; mem_ack = s.ack; mem_rdata = s.rdata; alu_zero = s.az;
      dec_halt = s.h; dec_branch = s.b; dec_mem_read = s.r; dec_mem_write = s.w; dec_reg_write = s.rw;
      #1;
      chk($sformatf("outs step%0d", checks), 32'(outs()), 32'(s.exp));
      chk($sformatf("ir step%0d", checks), 32'(ir), 32'(s.ir));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 0; mem_ack = 0; mem_rdata = '0; alu_zero = 0;
    dec_halt = 0; dec_branch = 0; dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0;
    @(negedge clk); #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_ir", 32'(ir), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ir = '0; m_halt = 1'b0; m_fault = 1'b0;
    f_h = 0; f_b = 0; f_r = 0; f_w = 0; f_rw = 0; f_az = 0;
  endtask

  initial begin
    // Literal ADD then HALT with zero-wait memory; cycle 1 is the first FETCH cycle.
    do_reset();
    @(negedge clk); run = 1; dec_reg_write = 1;
    @(negedge clk); run = 0; mem_ack = 1; mem_rdata = 16'h1000; #1;
    chk("add_c1_mem_req", 32'(mem_req), 32'h1);
    @(negedge clk); mem_ack = 0; #1;
    chk("add_c2_pc_inc", 32'(pc_inc), 32'h1);
    chk("add_ir", 32'(ir), 32'h1000);
    @(negedge clk); #1;
    chk("add_c3_quiet", 32'({pc_inc, pc_load_branch, reg_write_en, mem_req}), 32'h0);
    chk("add_c3_busy", 32'(busy), 32'h1);
    @(negedge clk); run = 1; #1;
    chk("add_c4_reg_write_en", 32'(reg_write_en), 32'h1);
    @(negedge clk); run = 0; mem_ack = 1; mem_rdata = 16'hF000; dec_reg_write = 0; dec_halt = 1; #1;
    chk("add_c5_refetch", 32'(mem_req), 32'h1);
    @(negedge clk); mem_ack = 0; #1;
    chk("halt_decode_pc_inc", 32'(pc_inc), 32'h1);
    @(negedge clk); #1;
    chk("halt_at_fetch_plus2", 32'({halted, busy}), 32'h2);

    // Model-driven program: mixed waits, branch taken/not, idle gaps, halt stickiness.
    do_reset();
    idle(2);
    instr(K_ALU, 0, 0, 1'b0, 1'b1);
    instr(K_LOAD, 1, 3, 1'b0, 1'b1);
    instr(K_STORE, 0, 2, 1'b0, 1'b1);
    instr(K_BR, 0, 0, 1'b1, 1'b1);
    instr(K_BR, 2, 0, 1'b0, 1'b0);
    idle(3);
    instr(K_NOP, 0, 0, 1'b0, 1'b1);
    instr(K_LOAD, 0, 0, 1'b1, 1'b0);
    idle(1);
    instr(K_STORE, 3, 0, 1'b0, 1'b1);
    instr(K_HALT, 0, 0, 1'b0, 1'b0);
    stuck(6);
    run_queue(q.size());

    // Long fetch wait: faults only when the timeout is built in.
    do_reset();
    idle(1);
    instr(K_ALU, 6, 0, 1'b0, 1'b0);
    if (m_fault) stuck(3); else idle(2);
    run_queue(q.size());

    // Ack exactly on the last allowed cycle, then a data-side timeout.
    do_reset();
    idle(1);
    instr(K_ALU, TO - 1, 0, 1'b0, 1'b0);
    idle(1);
    instr(K_LOAD, 0, TO - 1, 1'b0, 1'b0);
    idle(1);
    instr(K_LOAD, 0, TO + 1, 1'b0, 1'b0);
    if (m_fault) stuck(3); else idle(2);
    run_queue(q.size());

    // Asynchronous reset in the middle of a data access.
    do_reset();
    idle(1);
    instr(K_LOAD, 0, 8, 1'b0, 1'b0);
    run_queue(6);
    q.delete();
    chk("mid_mem_req_before_reset", 32'({mem_req, mem_data_sel}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'h0);
    chk("async_reset_ir", 32'(ir), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
